// File: rtl/mips_dbg_pkg.sv
// -----------------------------------------------------------------------------
// mips_dbg_pkg
// Shared definitions for the mips debug/bring-up blocks: the step controller
// now, and later debug blocks such as a breakpoint unit.
//
// Contents:
//   ST_RUN / ST_HALT / ST_PULSE : encodings for the step-controller FSM states
//   step_state_t                : enum built on those encodings
//   DEB_CYCLES_DEF              : default debounce length, in clocks
// -----------------------------------------------------------------------------
package mips_dbg_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;

    localparam int DEB_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        S_RUN   = ST_RUN,
        S_HALT  = ST_HALT,
        S_PULSE = ST_PULSE
    } step_state_t;

endpackage : mips_dbg_pkg

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Turns an asynchronous button/pin level into a clean, debounced level and a
// single-cycle rising-edge pulse.
//
// Chain: 2-flop synchroniser -> debouncer -> rising-edge detector.
// Pin-to-pulse latency is 2 + DEB_CYCLES clocks.
//
// Ports:
//   clock  in   system clock, all state on rising edge
//   reset  in   asynchronous, active-low
//   din    in   asynchronous input level
//   level  out  debounced level
//   rise   out  one-cycle pulse on each accepted 0->1 change of level
// -----------------------------------------------------------------------------
module btn_conditioner
    import mips_dbg_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    // The counter only runs while the synchronised sample differs from the
    // accepted level; any sample that agrees with the level restarts it. When
    // the DEB_CYCLES-th consecutive differing sample arrives, the level flips
    // and the edge pulse is registered in the same clock, so the pulse does
    // not cost an extra cycle of latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_rise <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_rise  <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule : btn_conditioner

// File: rtl/mips_step_ctrl.sv
// -----------------------------------------------------------------------------
// mips_step_ctrl
// Converts the change/step debug pins into a clock-enable for the mips core.
// RUN mode enables the core every cycle; HALT mode enables it for exactly one
// cycle per accepted step press. Also reports the mode and a running count of
// enabled cycles.
//
// Ports:
//   clock        in   system clock, all state on rising edge
//   reset        in   asynchronous, active-low; clears all state
//   change       in   async level; each accepted 0->1 edge toggles RUN/HALT
//   step         in   async level; each accepted 0->1 edge in HALT grants one
//                     core cycle
//   cpu_en       out  registered core clock-enable
//   halted       out  1 while in single-step mode (HALT or PULSE)
//   cycle_count  out  number of cpu_en=1 cycles since reset, wraps silently
// -----------------------------------------------------------------------------
module mips_step_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             change,
    input  logic             step,
    output logic             cpu_en,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count
);

    logic w_chg_rise;
    logic w_stp_rise;
    // Debounced levels are not needed here; the edge pulses carry everything.
    logic w_chg_level_unused;
    logic w_stp_level_unused;

    step_state_t r_state;
    step_state_t w_next_state;
    logic        r_pend_chg;
    logic        w_next_pend_chg;
    logic        r_cpu_en;
    logic        w_next_cpu_en;
    logic        r_halted;
    logic        w_next_halted;
    logic [CNT_W-1:0] r_cycle_count;

    btn_conditioner #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_chg_cond (
        .clock(clock),
        .reset(reset),
        .din  (change),
        .level(w_chg_level_unused),
        .rise (w_chg_rise)
    );

    btn_conditioner #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_stp_cond (
        .clock(clock),
        .reset(reset),
        .din  (step),
        .level(w_stp_level_unused),
        .rise (w_stp_rise)
    );

    // Next-state logic. A change edge that lands during the single PULSE
    // cycle cannot be acted on there (PULSE always returns to HALT so the
    // granted cycle is exactly one), so it is parked in pend_chg and taken
    // from HALT on the following cycle. Change beats step in HALT.
    always_comb begin
        w_next_state    = r_state;
        w_next_pend_chg = r_pend_chg;
        case (r_state)
            S_RUN: begin
                w_next_pend_chg = 1'b0;
                if (w_chg_rise) begin
                    w_next_state = S_HALT;
                end
            end
            S_HALT: begin
                if (w_chg_rise || r_pend_chg) begin
                    w_next_state    = S_RUN;
                    w_next_pend_chg = 1'b0;
                end else if (w_stp_rise) begin
                    w_next_state = S_PULSE;
                end
            end
            S_PULSE: begin
                w_next_state = S_HALT;
                if (w_chg_rise) begin
                    w_next_pend_chg = 1'b1;
                end
            end
            default: begin
                w_next_state    = S_RUN;
                w_next_pend_chg = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register together with
    // the state and line up with it cycle for cycle.
    always_comb begin
        w_next_cpu_en = (w_next_state == S_RUN) || (w_next_state == S_PULSE);
        w_next_halted = (w_next_state != S_RUN);
    end

    // Reset leaves cpu_en low even though the state is RUN; the core gets its
    // first enabled cycle on the first edge after release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_RUN;
            r_pend_chg <= 1'b0;
            r_cpu_en   <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pend_chg <= w_next_pend_chg;
            r_cpu_en   <= w_next_cpu_en;
            r_halted   <= w_next_halted;
        end
    end

    // Counts cycles in which the core was actually enabled; rolls over freely.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle_count <= '0;
        end else begin
            r_cycle_count <= r_cycle_count + CNT_W'(r_cpu_en);
        end
    end

    assign cpu_en      = r_cpu_en;
    assign halted      = r_halted;
    assign cycle_count = r_cycle_count;

endmodule : mips_step_ctrl

// File: tb/tb_mips_step_ctrl.sv
module tb_mips_step_ctrl;

  logic        clock;
  logic        reset;
  logic        change;
  logic        step;
  logic        cpu_en;
  logic        halted;
  logic [15:0] cycle_count;
  logic        cpu_en4;
  logic        halted4;
  logic [3:0]  cycle_count4;

  int checks;
  int failures;

  logic [15:0] exp_cnt;
  logic [31:0] exp_q[$];

  typedef struct {
    int   chg_start;
    int   chg_len;
    int   stp_start;
    int   stp_len;
    int   cycles;
    int   exp_n_en;
    int   exp_pulses;
    int   exp_delta;
    logic exp_halted;
  } vec_t;

  vec_t vecs[13];

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  mips_step_ctrl #(
    .DEB_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .change(change),
    .step(step),
    .cpu_en(cpu_en),
    .halted(halted),
    .cycle_count(cycle_count)
  );

  mips_step_ctrl #(
    .DEB_CYCLES(4),
    .CNT_W(4)
  ) dut4 (
    .clock(clock),
    .reset(reset),
    .change(change),
    .step(step),
    .cpu_en(cpu_en4),
    .halted(halted4),
    .cycle_count(cycle_count4)
  );

  // ---------------- scoreboard compare ----------------
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver: one table vector ----------------
  // Called at a negedge; pins change between posedges. Observes outputs on
  // the negedge following each posedge of the window.
  task automatic run_vec(input int idx);
    vec_t        v;
    int          n_en;
    int          pulses;
    logic [31:0] e;
    string       tag;
    v = vecs[idx];
    n_en = 0;
    pulses = 0;
    exp_q.push_back({8'(v.exp_n_en), 8'(v.exp_pulses), 8'(v.exp_delta), 7'd0, v.exp_halted});
    exp_cnt = exp_cnt + 16'(v.exp_delta);
    for (int k = 0; k < v.cycles; k++) begin
      change = (v.chg_len > 0) && (k >= v.chg_start) && (k < v.chg_start + v.chg_len);
      step   = (v.stp_len > 0) && (k >= v.stp_start) && (k < v.stp_start + v.stp_len);
      @(posedge clock);
      @(negedge clock);
      n_en += int'(cpu_en);
      pulses += int'(cpu_en && halted);
    end
    change = 1'b0;
    step = 1'b0;
    e = exp_q.pop_front();
    tag = $sformatf("v%0d", idx);
    check({tag, "_en_cycles"}, n_en, e[31:24]);
    check({tag, "_pulses"}, pulses, e[23:16]);
    check({tag, "_halted"}, halted, e[0]);
    check({tag, "_count"}, cycle_count, exp_cnt);
    check({tag, "_count4"}, cycle_count4, exp_cnt[3:0]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    change = 1'b0;
    step = 1'b0;

    // {chg_start, chg_len, stp_start, stp_len, cycles, n_en, pulses, delta, halted}
    vecs[0]  = '{0, 0, 0, 0, 16, 16, 0, 16, 1'b0};  // idle in RUN
    vecs[1]  = '{0, 8, 0, 0, 16,  6, 0,  7, 1'b1};  // change -> HALT
    vecs[2]  = '{0, 0, 0, 8, 16,  1, 1,  1, 1'b1};  // step 1
    vecs[3]  = '{0, 0, 0, 8, 16,  1, 1,  1, 1'b1};  // step 2
    vecs[4]  = '{0, 0, 0, 8, 16,  1, 1,  1, 1'b1};  // step 3
    vecs[5]  = '{0, 0, 0, 2, 16,  0, 0,  0, 1'b1};  // step glitch
    vecs[6]  = '{0, 3, 0, 0, 16,  0, 0,  0, 1'b1};  // change glitch
    vecs[7]  = '{0, 0, 0, 12, 20, 1, 1,  1, 1'b1};  // long step: one pulse only
    vecs[8]  = '{0, 8, 0, 8, 16, 10, 0,  9, 1'b0};  // change+step same cycle -> RUN
    vecs[9]  = '{0, 8, 0, 0, 16,  6, 0,  7, 1'b1};  // change -> HALT
    vecs[10] = '{1, 8, 0, 8, 16,  9, 1,  8, 1'b0};  // change lands in PULSE
    vecs[11] = '{0, 0, 0, 8, 16, 16, 0, 16, 1'b0};  // step ignored in RUN
    vecs[12] = '{0, 8, 0, 0, 16,  6, 0,  7, 1'b1};  // change -> HALT

    // Reset held 3 cycles
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_halted", halted, 0);
    check("rst_count", cycle_count, 0);
    check("rst_count4", cycle_count4, 0);
    reset = 1'b1;

    @(posedge clock);
    @(negedge clock);
    check("first_cpu_en", cpu_en, 1);
    check("first_halted", halted, 0);
    check("first_count", cycle_count, 0);
    repeat (10) begin
      @(posedge clock);
      @(negedge clock);
    end
    check("count_after_10", cycle_count, 10);
    repeat (7) begin
      @(posedge clock);
      @(negedge clock);
    end
    check("count_after_17", cycle_count, 17);
    check("count4_wrap", cycle_count4, 1);
    exp_cnt = 16'd17;

    for (int i = 0; i < 13; i++) begin
      run_vec(i);
    end

    // Reset asserted in the middle of a PULSE cycle (state is HALT here)
    for (int k = 0; k < 7; k++) begin
      step = 1'b1;
      @(posedge clock);
      @(negedge clock);
    end
    check("pulse_cpu_en", cpu_en, 1);
    check("pulse_halted", halted, 1);
    #1 reset = 1'b0;
    #1;
    check("midpulse_rst_cpu_en", cpu_en, 0);
    check("midpulse_rst_halted", halted, 0);
    check("midpulse_rst_count", cycle_count, 0);
    check("midpulse_rst_count4", cycle_count4, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    // step still held high across release: its edge arrives in RUN and is ignored
    @(posedge clock);
    @(negedge clock);
    check("rerelease_cpu_en", cpu_en, 1);
    check("rerelease_count", cycle_count, 0);
    repeat (10) begin
      @(posedge clock);
      @(negedge clock);
    end
    check("held_step_halted", halted, 0);
    check("held_step_count", cycle_count, 10);
    step = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mips_step_ctrl
